// File: rtl/big_address_pkg.sv
// Shared types and defaults for the Big_Address sequencer and its helpers.
package big_address_pkg;

    localparam int BLOCK_SIZE = 16;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_CNT_W  = 16;
    localparam int LAT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/seq_lat_counter.sv
// Loadable down-counter timing the gap between a block's read and write strobes.
module seq_lat_counter
    import big_address_pkg::*;
#(
    parameter int W = LAT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    input  logic         i_hold,
    output logic         o_zero_next
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (!i_hold) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // High when the current decrement is the one that takes the count to zero.
    assign o_zero_next = (r_count == W'(1));

endmodule

// File: rtl/big_address_sequencer.sv
// Steps Big_Address through a memory region, one read/wait/write pass per 16-word block.
//
// state | meaning
// IDLE  | waiting for start; address and block count hold
// READ  | one-cycle read strobe for the current block
// WAIT  | processing latency countdown
// WRITE | one-cycle write strobe; block completes here
// DONE  | one-cycle done pulse, then back to IDLE
module big_address_sequencer
    import big_address_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BLOCK    = BLOCK_SIZE,
    parameter int PROC_LAT = 2,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_num_blocks,
    input  logic              i_stall,
    output logic [ADDR_W-1:0] o_current_address,
    output logic              o_rd_en,
    output logic              o_wr_en,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_block_cnt
);

    seq_state_e        r_state;
    seq_state_e        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_rd;
    logic              w_wr;
    logic              w_busy;
    logic              w_done;
    logic              w_lat_load;
    logic              w_lat_zero_next;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    seq_lat_counter #(.W(LAT_W)) u_lat (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_lat_load),
        .i_load_val  (LAT_W'(PROC_LAT)),
        .i_dec       (r_state == ST_WAIT),
        .i_hold      (i_stall),
        .o_zero_next (w_lat_zero_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_lat_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = (i_num_blocks == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                w_busy = 1'b1;
                if (!i_stall) begin
                    w_rd       = 1'b1;
                    w_lat_load = 1'b1;
                    w_next     = (PROC_LAT == 0) ? ST_WRITE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (!i_stall && w_lat_zero_next) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_busy = 1'b1;
                if (!i_stall) begin
                    w_wr   = 1'b1;
                    w_next = (w_cnt_inc == r_num) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // An empty run still reports zero completed blocks but leaves the address alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_num  <= '0;
            r_cnt  <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_cnt <= '0;
            if (i_num_blocks != '0) begin
                r_addr <= i_base_addr;
                r_num  <= i_num_blocks;
            end
        end else if ((r_state == ST_WRITE) && !i_stall) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc != r_num) begin
                r_addr <= r_addr + ADDR_W'(BLOCK);
            end
        end
    end

    assign o_current_address = r_addr;
    assign o_block_cnt       = r_cnt;
    assign o_rd_en           = w_rd;
    assign o_wr_en           = w_wr;
    assign o_busy            = w_busy;
    assign o_done            = w_done;

endmodule

// File: tb/tb_big_address_sequencer.sv
// Self-checking bench: per-cycle outputs compared against a slot-count model of the run.
module tb_big_address_sequencer;

    localparam int AW = 32;
    localparam int CW = 16;
    localparam int L  = 2;
    localparam int BS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_blocks = '0;
    logic [AW-1:0] cur_addr;
    logic          rd_en;
    logic          wr_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] block_cnt;

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] hold_addr = '0;

    big_address_sequencer #(
        .ADDR_W   (AW),
        .BLOCK    (BS),
        .PROC_LAT (L),
        .CNT_W    (CW)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .i_base_addr       (base_addr),
        .i_num_blocks      (num_blocks),
        .i_stall           (stall),
        .o_current_address (cur_addr),
        .o_rd_en           (rd_en),
        .o_wr_en           (wr_en),
        .o_busy            (busy),
        .o_done            (done),
        .o_block_cnt       (block_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Model: every unstalled busy cycle consumes one slot; a block needs L+2 slots
    // (read, L idle, write). Slot index decides strobe, block number and address.
    task automatic run_and_check(input logic [AW-1:0] base, input int n, input int stall_pct,
                                 input int stall_at_p, input int stall_len,
                                 input int mid_start_cyc, output int done_cyc);
        int            p;
        int            total;
        int            cyc;
        int            used;
        logic          st;
        logic          e_rd, e_wr, e_busy, e_done;
        logic [AW-1:0] e_addr;
        logic [CW-1:0] e_cnt;
        logic [AW-1:0] fin_addr;
        logic [CW-1:0] fin_cnt;
        total    = n * (L + 2);
        p        = 0;
        cyc      = 1;
        used     = 0;
        done_cyc = -1;
        fin_addr = (n == 0) ? hold_addr : base + AW'(BS * (n - 1));
        fin_cnt  = CW'(n);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = base;
        num_blocks = CW'(n);
        stall      = 1'($urandom_range(1));
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = ~base;
        num_blocks = CW'($urandom);
        while ((p <= total + 1) && (cyc < 2000)) begin
            st = 1'b0;
            if ((stall_pct > 0) && (int'($urandom_range(99)) < stall_pct)) st = 1'b1;
            if ((p == stall_at_p) && (used < stall_len)) begin
                st = 1'b1;
                used++;
            end
            stall = st;
            if (cyc == mid_start_cyc) begin
                start      = 1'b1;
                base_addr  = 32'h500;
                num_blocks = CW'(7);
            end else begin
                start = 1'b0;
            end
            if (p < total) begin
                e_busy = 1'b1;
                e_done = 1'b0;
                e_rd   = !st && ((p % (L + 2)) == 0);
                e_wr   = !st && ((p % (L + 2)) == L + 1);
                e_addr = base + AW'(BS * (p / (L + 2)));
                e_cnt  = CW'(p / (L + 2));
            end else begin
                e_busy = 1'b0;
                e_done = (p == total);
                e_rd   = 1'b0;
                e_wr   = 1'b0;
                e_addr = fin_addr;
                e_cnt  = fin_cnt;
                if (p == total) done_cyc = cyc;
            end
            @(negedge clk);
            checks++;
            if ({rd_en, wr_en, busy, done, cur_addr, block_cnt} !==
                {e_rd, e_wr, e_busy, e_done, e_addr, e_cnt}) begin
                errors++;
                $display("FAIL run cyc=%0d rd/wr/busy/done got=%b%b%b%b exp=%b%b%b%b addr got=%h exp=%h cnt got=%0d exp=%0d",
                         cyc, rd_en, wr_en, busy, done, e_rd, e_wr, e_busy, e_done,
                         cur_addr, e_addr, block_cnt, e_cnt);
            end
            if ((p >= total) || !st) p++;
            cyc++;
            @(posedge clk); #1;
        end
        if (p <= total + 1) begin
            errors++;
            $display("FAIL run_timeout got=cycles %0d exp=completion", cyc);
        end
        stall     = 1'b0;
        start     = 1'b0;
        hold_addr = fin_addr;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        start      = 1'b1;
        num_blocks = CW'(3);
        @(negedge clk);
        checks++;
        if ({rd_en, wr_en, busy, done, cur_addr, block_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b%b addr=%h cnt=%0d exp=all zero",
                     rd_en, wr_en, busy, done, cur_addr, block_cnt);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, cur_addr} !== '0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b addr=%h exp=0 0 0", busy, done, cur_addr);
        end
    endtask

    task automatic test_empty();
        int dc;
        run_and_check(32'h1234, 0, 0, -1, 0, -1, dc);
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL empty_done_cycle got=%0d exp=1", dc);
        end
    endtask

    task automatic test_two_block();
        int dc;
        run_and_check(32'h100, 2, 0, -1, 0, -1, dc);
        checks++;
        if (dc !== 9) begin
            errors++;
            $display("FAIL two_block_done_cycle got=%0d exp=9", dc);
        end
    endtask

    task automatic test_stall();
        int dc;
        run_and_check(32'h200, 2, 0, L + 1, 3, -1, dc);
        checks++;
        if (dc !== 12) begin
            errors++;
            $display("FAIL stall_done_cycle got=%0d exp=12", dc);
        end
    endtask

    task automatic test_wrap();
        int dc;
        run_and_check(32'hFFFF_FFF0, 2, 0, -1, 0, -1, dc);
        checks++;
        if ((dc !== 9) || (cur_addr !== 32'h0)) begin
            errors++;
            $display("FAIL wrap got done_cyc=%0d addr=%h exp=9 00000000", dc, cur_addr);
        end
    endtask

    task automatic test_start_while_busy();
        int dc;
        run_and_check(32'h700, 3, 0, -1, 0, 3, dc);
        checks++;
        if (dc !== 13) begin
            errors++;
            $display("FAIL busy_start_done_cycle got=%0d exp=13", dc);
        end
    endtask

    task automatic test_reset_mid_run();
        int dc;
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = 32'h800;
        num_blocks = CW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, rd_en, wr_en} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_precond got busy/rd/wr=%b exp=100", {busy, rd_en, wr_en});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, wr_en, busy, done, cur_addr, block_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async got=%b%b%b%b addr=%h cnt=%0d exp=all zero",
                     rd_en, wr_en, busy, done, cur_addr, block_cnt);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        hold_addr = '0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_no_done got busy/done=%b exp=00", {busy, done});
        end
        run_and_check(32'h3000, 1, 0, -1, 0, -1, dc);
        checks++;
        if (dc !== 5) begin
            errors++;
            $display("FAIL mid_reset_rerun_done_cycle got=%0d exp=5", dc);
        end
    endtask

    task automatic test_random();
        int dc;
        for (int r = 0; r < 8; r++) begin
            run_and_check($urandom, int'($urandom_range(4, 1)), 30, -1, 0, -1, dc);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_two_block();
        test_stall();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
